// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle for uart_tx_frame.
// The master side offers words; the slave side (the transmitter) drives the line.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_ready;
    logic                 o_txd;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_txd, o_busy, o_done
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_txd, o_busy, o_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Configurable asynchronous serial transmitter: start, 5-9 data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, with an internal baud divider.
module uart_tx_frame #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic             i_clk,
    input logic             i_reset,
    uart_tx_frame_if.slave  bus
);
    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("uart_tx_frame: CLK_DIV must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_INV  = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;

    logic bit_end, last_stop, ready, accept;

    assign bit_end   = (state_q != IDLE) && (cnt_q == CNT_MAX);
    assign last_stop = (state_q == STOP) && bit_end && (stp_q == STP_LAST);
    assign ready     = (state_q == IDLE) || last_stop;
    assign accept    = bus.i_valid && ready;

    assign bus.o_ready = ready;
    assign bus.o_txd   = txd_q;
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_done  = last_stop;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stp_q   <= 1'b0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stp_q   <= stp_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        stp_d   = stp_q;
        sr_d    = sr_q;
        par_d   = par_q;
        txd_d   = txd_q;
        // Word load is shared by IDLE and the final stop bit so frames abut.
        if (accept) begin
            state_d = START;
            txd_d   = 1'b0;
            sr_d    = bus.i_data;
            par_d   = (^bus.i_data) ^ PAR_INV;
        end else begin
            case (state_q)
                START: if (bit_end) begin
                    state_d = DATA;
                    txd_d   = sr_q[0];
                    sr_d    = sr_q >> 1;
                    idx_d   = '0;
                end
                DATA: if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                            stp_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        txd_d = sr_q[0];
                        sr_d  = sr_q >> 1;
                    end
                end
                PAR: if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    stp_d   = 1'b0;
                end
                STOP: if (bit_end) begin
                    if (stp_q != STP_LAST) begin
                        stp_d = stp_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations, per-cycle line checks.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] valid;
    logic [8:0] data [4];
    logic [3:0] txd, busy, ready, done;

    typedef struct packed {
        logic txd;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    exp_t expq[$];
    int   act;
    int   n_tests;
    int   n_fail;

    uart_tx_frame_if #(.DATA_BITS(8)) ifa ();
    uart_tx_frame_if #(.DATA_BITS(8)) ifb ();
    uart_tx_frame_if #(.DATA_BITS(8)) ifc ();
    uart_tx_frame_if #(.DATA_BITS(7)) ifd ();

    assign ifa.i_valid = valid[0];
    assign ifa.i_data  = data[0][7:0];
    assign ifb.i_valid = valid[1];
    assign ifb.i_data  = data[1][7:0];
    assign ifc.i_valid = valid[2];
    assign ifc.i_data  = data[2][7:0];
    assign ifd.i_valid = valid[3];
    assign ifd.i_data  = data[3][6:0];
    assign txd   = {ifd.o_txd,   ifc.o_txd,   ifb.o_txd,   ifa.o_txd};
    assign busy  = {ifd.o_busy,  ifc.o_busy,  ifb.o_busy,  ifa.o_busy};
    assign ready = {ifd.o_ready, ifc.o_ready, ifb.o_ready, ifa.o_ready};
    assign done  = {ifd.o_done,  ifc.o_done,  ifb.o_done,  ifa.o_done};

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_b (.i_clk(clk), .i_reset(rst), .bus(ifb));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_c (.i_clk(clk), .i_reset(rst), .bus(ifc));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        u_d (.i_clk(clk), .i_reset(rst), .bus(ifd));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, built from the frame format.
    task automatic push_frame(input int k, input logic [8:0] d);
        int   db, par, sb;
        logic bits[$];
        logic p;
        exp_t e;
        db  = (k == 3) ? 7 : 8;
        par = (k == 1) ? 1 : (k == 2) ? 2 : 0;
        sb  = (k == 3) ? 2 : 1;
        p   = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 1) bits.push_back(p);
        if (par == 2) bits.push_back(~p);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < 4; c++) begin
                e.txd   = bits[b];
                e.busy  = 1'b1;
                e.ready = (b == bits.size() - 1) && (c == 3);
                e.done  = e.ready;
                expq.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("txd",   32'(txd[act]),   32'(e.txd));
            chk("busy",  32'(busy[act]),  32'(e.busy));
            chk("ready", 32'(ready[act]), 32'(e.ready));
            chk("done",  32'(done[act]),  32'(e.done));
        end
    end

    // Called at negedge+2; returns just after the accepting edge.
    task automatic send(input int k, input logic [8:0] d);
        int t;
        act      = k;
        valid[k] = 1'b1;
        data[k]  = d;
        t = 0;
        while (!ready[k] && t < 200) begin
            @(negedge clk); #2;
            t++;
        end
        if (t >= 200) begin
            chk("ready_timeout", 32'(ready[k]), 32'd1);
        end else begin
            push_frame(k, d);
            @(posedge clk);
        end
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (expq.size() > 0 && t < 300) begin
            @(negedge clk); #2;
            t++;
        end
        chk("drain", 32'(expq.size()), 32'd0);
        @(negedge clk); #2;
        chk("idle_txd",   32'(txd[k]),   32'd1);
        chk("idle_busy",  32'(busy[k]),  32'd0);
        chk("idle_ready", 32'(ready[k]), 32'd1);
    endtask

    task automatic check_idle_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_txd"},   32'(txd[k]),   32'd1);
            chk({tag, "_busy"},  32'(busy[k]),  32'd0);
            chk({tag, "_ready"}, 32'(ready[k]), 32'd1);
            chk({tag, "_done"},  32'(done[k]),  32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        act     = 0;
        rst     = 1'b1;
        valid   = '0;
        for (int k = 0; k < 4; k++) data[k] = '0;
        repeat (2) @(negedge clk);
        #2;
        check_idle_all("reset");
        rst = 1'b0;
        @(negedge clk); #2;

        // 8N1 0xA5, even parity 0x07, odd parity 0x00, 7N2 0x41
        send(0, 9'h0A5); @(negedge clk); #2; valid[0] = 1'b0; wait_idle(0);
        send(1, 9'h007); @(negedge clk); #2; valid[1] = 1'b0; wait_idle(1);
        send(2, 9'h000); @(negedge clk); #2; valid[2] = 1'b0; wait_idle(2);
        send(3, 9'h041); @(negedge clk); #2; valid[3] = 1'b0; wait_idle(3);

        // back-to-back: data changes right after acceptance, valid stays high
        send(0, 9'h055);
        @(negedge clk); #2;
        data[0] = 9'h0AA;
        send(0, 9'h0AA);
        @(negedge clk); #2; valid[0] = 1'b0;
        wait_idle(0);

        // reset during data bit 3 (frame cycles 17..20; d3 of 0x07 is 0)
        send(0, 9'h007);
        @(negedge clk); #2; valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        #2;
        rst = 1'b1;
        expq.delete();
        #1;
        check_idle_all("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_done", 32'(done[0]), 32'd0);
        end
        #2;
        rst = 1'b0;
        @(negedge clk); #2;
        send(0, 9'h03C); @(negedge clk); #2; valid[0] = 1'b0; wait_idle(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
